// File: rtl/vx_warp_ibuffer.sv
// vx_warp_ibuffer: per-warp instruction FIFOs with a round-robin
// arbiter feeding a registered valid/ready dispatch output.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   valid_in        - decoded instruction valid
//   ready_in        - instruction accepted (warp FIFO not full)
//   wid_in, data_in - warp id and payload of incoming instruction
//   valid_out       - instruction presented to dispatch
//   ready_out       - dispatch accepts the presented instruction
//   wid_out         - warp id of presented instruction
//   data_out        - presented payload
//   warp_full       - per-warp FIFO full flags back to fetch
module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int DATAW     = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [$clog2(NUM_WARPS)-1:0] wid_in,
    input  logic [DATAW-1:0]             data_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [$clog2(NUM_WARPS)-1:0] wid_out,
    output logic [DATAW-1:0]             data_out,
    output logic [NUM_WARPS-1:0]         warp_full
);

    localparam int WW = $clog2(NUM_WARPS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATAW-1:0] mem [NUM_WARPS][DEPTH];
    logic [PW-1:0]    rd_ptr [NUM_WARPS];
    logic [PW-1:0]    wr_ptr [NUM_WARPS];
    logic [CW-1:0]    count  [NUM_WARPS];
    logic [WW-1:0]    rr_ptr;

    logic [NUM_WARPS-1:0] req;
    logic [WW-1:0]        gnt;
    logic [WW-1:0]        idx;
    logic                 gnt_any;
    logic                 push;
    logic                 pop;
    logic                 load_en;

    // Full flags come straight from the count registers, so ready_in
    // only depends on wid_in and registered state.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_full[w] = (count[w] == CW'(DEPTH));
            req[w]       = (count[w] != '0);
        end
    end

    assign ready_in = !warp_full[wid_in];
    assign push     = valid_in && ready_in;
    assign load_en  = !valid_out || ready_out;
    assign pop      = load_en && gnt_any;

    // First requester at or after rr_ptr; the index wraps naturally
    // because NUM_WARPS is a power of two.
    always_comb begin
        gnt     = rr_ptr;
        gnt_any = 1'b0;
        idx     = rr_ptr;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr + WW'(i);
            if (!gnt_any && req[idx]) begin
                gnt     = idx;
                gnt_any = 1'b1;
            end
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wid_in][wr_ptr[wid_in]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                count[w]  <= '0;
            end
            rr_ptr    <= '0;
            valid_out <= 1'b0;
            wid_out   <= '0;
            data_out  <= '0;
        end else begin
            if (push) begin
                wr_ptr[wid_in] <= wr_ptr[wid_in] + PW'(1);
            end
            if (pop) begin
                rd_ptr[gnt] <= rd_ptr[gnt] + PW'(1);
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                count[w] <= count[w]
                          + CW'(push && (wid_in == WW'(w)))
                          - CW'(pop && (gnt == WW'(w)));
            end
            if (load_en) begin
                valid_out <= gnt_any;
                if (gnt_any) begin
                    wid_out  <= gnt;
                    data_out <= mem[gnt][rd_ptr[gnt]];
                    rr_ptr   <= gnt + WW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// tb_vx_warp_ibuffer: directed vector bench for vx_warp_ibuffer.
// Each step drives inputs, checks ready_in, clocks, checks outputs.
module tb_vx_warp_ibuffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic         ready_in;
    logic [1:0]   wid_in;
    logic [127:0] data_in;
    logic         valid_out;
    logic         ready_out;
    logic [1:0]   wid_out;
    logic [127:0] data_out;
    logic [3:0]   warp_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic         vi;
        logic [1:0]   wid;
        logic [127:0] din;
        logic         ro;
        logic         e_rdy;
        logic         e_vo;
        logic [1:0]   e_wid;
        logic [127:0] e_data;
        logic [3:0]   e_full;
    } vec_t;

    vec_t tbl[$];

    vx_warp_ibuffer #(
        .NUM_WARPS(4),
        .DEPTH(4),
        .DATAW(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .wid_in(wid_in),
        .data_in(data_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .wid_out(wid_out),
        .data_out(data_out),
        .warp_full(warp_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic vi,
        input logic [1:0] wid, input logic [127:0] din,
        input logic ro, input logic e_rdy, input logic e_vo,
        input logic [1:0] e_wid, input logic [127:0] e_data,
        input logic [3:0] e_full);
        vec_t v;
        v.rst = rst; v.vi = vi; v.wid = wid; v.din = din;
        v.ro = ro; v.e_rdy = e_rdy; v.e_vo = e_vo;
        v.e_wid = e_wid; v.e_data = e_data; v.e_full = e_full;
        return v;
    endfunction

    // wid_out/data_out are only compared while valid_out is expected.
    task automatic step(input string tag, input vec_t v);
        reset     = v.rst;
        valid_in  = v.vi;
        wid_in    = v.wid;
        data_in   = v.din;
        ready_out = v.ro;
        #1;
        chk({tag, ".ready_in"}, 128'(ready_in), 128'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".valid_out"}, 128'(valid_out), 128'(v.e_vo));
        chk({tag, ".warp_full"}, 128'(warp_full), 128'(v.e_full));
        if (v.e_vo) begin
            chk({tag, ".wid_out"}, 128'(wid_out), 128'(v.e_wid));
            chk({tag, ".data_out"}, data_out, v.e_data);
        end
    endtask

    task automatic go(input string tag,
                      input logic vi, input logic [1:0] wid,
                      input logic [127:0] din, input logic ro,
                      input logic e_rdy, input logic e_vo,
                      input logic [1:0] e_wid,
                      input logic [127:0] e_data,
                      input logic [3:0] e_full);
        step(tag, mk(1'b0, vi, wid, din, ro, e_rdy, e_vo,
                     e_wid, e_data, e_full));
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; wid_in = '0;
        data_in = '0; ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid_out", 128'(valid_out), 128'(0));
        chk("rst.wid_out", 128'(wid_out), 128'(0));
        chk("rst.data_out", data_out, 128'(0));
        chk("rst.warp_full", 128'(warp_full), 128'(0));
        reset = 1'b0;
        #1;
        chk("rst.ready_in", 128'(ready_in), 128'(1));

        // single-warp latency: push at edge N, visible after N+1
        tbl.push_back(mk(0,1,2,'hA5,1, 1,0,0,0,0));
        tbl.push_back(mk(0,0,2,0,1,    1,1,2,'hA5,0));
        tbl.push_back(mk(0,0,2,0,1,    1,0,0,0,0));
        // output register grabs a warp-0 item, then fill warp 1
        tbl.push_back(mk(0,1,0,'h77,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,    1,1,0,'h77,0));
        tbl.push_back(mk(0,1,1,1,0,    1,1,0,'h77,0));
        tbl.push_back(mk(0,1,1,2,0,    1,1,0,'h77,0));
        tbl.push_back(mk(0,1,1,3,0,    1,1,0,'h77,4'b0010));
        tbl.push_back(mk(0,1,1,4,0,    0,1,0,'h77,4'b0010));
        // drain warp 1 in order
        tbl.push_back(mk(0,0,1,0,1,    0,1,1,0,0));
        tbl.push_back(mk(0,0,1,0,1,    1,1,1,1,0));
        tbl.push_back(mk(0,0,1,0,1,    1,1,1,2,0));
        tbl.push_back(mk(0,0,1,0,1,    1,1,1,3,0));
        tbl.push_back(mk(0,0,1,0,1,    1,0,0,0,0));
        foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

        // round robin: rr_ptr=2 here; expect 0,1,3,0,1,3
        go("rr1",1,0,'h10,0, 1,0,0,0,0);
        go("rr2",1,0,'h11,0, 1,1,0,'h10,0);
        go("rr3",1,1,'h20,0, 1,1,0,'h10,0);
        go("rr4",1,1,'h21,0, 1,1,0,'h10,0);
        go("rr5",1,3,'h30,0, 1,1,0,'h10,0);
        go("rr6",1,3,'h31,0, 1,1,0,'h10,0);
        go("rr7",0,0,0,1,    1,1,1,'h20,0);
        go("rr8",0,0,0,1,    1,1,3,'h30,0);
        go("rr9",0,0,0,1,    1,1,0,'h11,0);
        go("rr10",0,0,0,1,   1,1,1,'h21,0);
        go("rr11",0,0,0,1,   1,1,3,'h31,0);
        go("rr12",0,0,0,1,   1,0,0,0,0);

        // backpressure: hold wid1/0x33 while other warps fill
        go("bp1",1,1,'h33,0, 1,0,0,0,0);
        go("bp2",0,1,0,0,    1,1,1,'h33,0);
        go("bp3",1,0,'h40,0, 1,1,1,'h33,0);
        go("bp4",1,3,'h41,0, 1,1,1,'h33,0);
        go("bp5",1,2,'h42,0, 1,1,1,'h33,0);
        go("bp6",1,0,'h43,0, 1,1,1,'h33,0);
        go("bp7",1,3,'h44,0, 1,1,1,'h33,0);
        go("bp8",0,0,0,1,    1,1,2,'h42,0);
        go("bp9",0,0,0,1,    1,1,3,'h41,0);
        go("bp10",0,0,0,1,   1,1,0,'h40,0);
        go("bp11",0,0,0,1,   1,1,3,'h44,0);
        go("bp12",0,0,0,1,   1,1,0,'h43,0);
        go("bp13",0,0,0,1,   1,0,0,0,0);

        // simultaneous push/pop with warp 0 holding 3 entries
        go("pp1",1,0,'h100,0, 1,0,0,0,0);
        go("pp2",1,0,'h101,0, 1,1,0,'h100,0);
        go("pp3",1,0,'h102,0, 1,1,0,'h100,0);
        go("pp4",1,0,'h103,0, 1,1,0,'h100,0);
        for (int i = 0; i < 10; i++) begin
            go($sformatf("pp_loop%0d", i), 1, 0,
               128'h104 + 128'(i), 1, 1, 1, 0,
               128'h101 + 128'(i), 0);
        end
        go("pp_d1",0,0,0,1, 1,1,0,'h10B,0);
        go("pp_d2",0,0,0,1, 1,1,0,'h10C,0);
        go("pp_d3",0,0,0,1, 1,1,0,'h10D,0);
        go("pp_d4",0,0,0,1, 1,0,0,0,0);

        // reset mid-operation with every warp occupied
        go("rm1",1,0,'h50,0, 1,0,0,0,0);
        go("rm2",1,1,'h51,0, 1,1,0,'h50,0);
        go("rm3",1,2,'h52,0, 1,1,0,'h50,0);
        go("rm4",1,3,'h53,0, 1,1,0,'h50,0);
        go("rm5",1,0,'h54,0, 1,1,0,'h50,0);
        step("rm_rst", mk(1,1,1,'h55,0, 1,0,0,0,0));
        chk("rm.wid_out", 128'(wid_out), 128'(0));
        chk("rm.data_out", data_out, 128'(0));
        go("rm6",1,3,'hBEEF,1, 1,0,0,0,0);
        go("rm7",0,0,0,1,      1,1,3,'hBEEF,0);
        go("rm8",0,0,0,1,      1,0,0,0,0);
        go("rm9",0,0,0,1,      1,0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
